mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles spent waiting for i_Mem_Ready before abort (legal 2..65535).
REQ-002 SHALL have port i_Clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port i_Rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port BUS_IN  input  16  processor bus value (BUS_DRIVER output).
REQ-005 SHALL have port LD_MAR  input  1  load MAR from BUS_IN.
REQ-006 SHALL have port LD_MDR  input  1  load MDR from BUS_IN (when MIO_EN=0).
REQ-007 SHALL have port MIO_EN  input  1  memory access request from control FSM.
REQ-008 SHALL have port R_W  input  1  access direction: 0 read, 1 write.
REQ-009 SHALL have port i_Mem_Rdata  input  16  memory read data.
REQ-010 SHALL have port i_Mem_Ready  input  1  memory completion strobe.
REQ-011 SHALL have port o_Mem_Addr  output  16  memory address (= MAR).
REQ-012 SHALL have port o_Mem_Wdata  output  16  memory write data (= MDR).
REQ-013 SHALL have port o_Mem_Req  output  1  access in progress.
REQ-014 SHALL have port o_Mem_We  output  1  write enable, valid only with o_Mem_Req.
REQ-015 SHALL have port MAR_OUT  output  16  MAR contents.
REQ-016 SHALL have port MDR_OUT  output  16  MDR contents, drives BUS_DRIVER MDR_OUT.
REQ-017 SHALL have port R  output  1  access-complete pulse to control FSM.
REQ-018 SHALL have port o_Err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, DONE; o_Mem_Req, o_Mem_We, R decoded from state only (Moore).
REQ-020 SHALL in IDLE with MIO_EN=1 go to READ (R_W=0) or WRITE (R_W=1) on next edge; clear o_Err on that edge.
REQ-021 SHALL drive o_Mem_Req=1 in READ/WRITE, o_Mem_We=1 only in WRITE, both 0 in IDLE/DONE.
REQ-022 SHALL in READ on edge with i_Mem_Ready=1 capture i_Mem_Rdata into MDR and go to DONE.
REQ-023 SHALL in WRITE on edge with i_Mem_Ready=1 go to DONE; MDR unchanged.
REQ-024 SHALL assert R=1 only in DONE, exactly one cycle; DONE always returns to IDLE next edge.
REQ-025 SHALL give minimum latency 2 edges from MIO_EN sampled in IDLE to R high (Ready present first READ/WRITE cycle).
REQ-026 SHALL count cycles in READ/WRITE (16-bit, cleared on entry); when count reaches TIMEOUT_CYCLES-1 without Ready, go to DONE, set o_Err=1, leave MDR unchanged.
REQ-027 SHALL give i_Mem_Ready priority over timeout when both occur same edge (no error, data captured).
REQ-028 SHALL load MAR from BUS_IN when LD_MAR=1 only in IDLE or DONE; ignored in READ/WRITE (address stable during access).
REQ-029 SHALL load MDR from BUS_IN when LD_MDR=1 and MIO_EN=0 in IDLE or DONE; ignored in READ/WRITE.
REQ-030 SHALL ignore i_Mem_Ready in IDLE and DONE.
REQ-031 SHALL drive o_Mem_Addr=MAR, o_Mem_Wdata=MDR, MAR_OUT=MAR, MDR_OUT=MDR continuously.
REQ-032 SHALL hold o_Err until the next accepted request (REQ-020) or reset.

Reset
REQ-033 SHALL on i_Rst=1, asynchronously: state IDLE, MAR=0x0000, MDR=0x0000, counter=0, o_Err=0; hence o_Mem_Req=0, o_Mem_We=0, R=0 immediately.
REQ-034 SHALL abort any in-flight access on reset with no R pulse and no MDR update.

Structure
REQ-035 SHALL place state enumeration and WORD_W=16 constant in shared package lc3_mem_pkg.
REQ-036 SHALL use one sub-module mem_timeout_ctr (clear, enable, terminal-count output) for the wait counter.

Verification
REQ-037 Read: MAR<=0x3000 via LD_MAR, MIO_EN=1 R_W=0, Ready+Rdata=0xBEEF one cycle later -> o_Mem_Addr=0x3000, We=0, MDR=0xBEEF, R one cycle.
REQ-038 Write: LD_MDR BUS_IN=0x1234, MAR=0x4000, MIO_EN=1 R_W=1, Ready after 5 cycles -> Req/We high 5 cycles, Wdata=0x1234, R one cycle, MDR=0x1234.
REQ-039 Timeout: TIMEOUT_CYCLES=8, read, Ready never -> R after 8 READ cycles, o_Err=1, MDR unchanged; next request clears o_Err.
REQ-040 Race: Ready on exact terminal-count edge -> o_Err=0, MDR=Rdata.
REQ-041 Busy loads: LD_MAR BUS_IN=0xFFFF and LD_MDR during READ -> MAR, MDR, o_Mem_Addr unchanged.
REQ-042 Reset mid-WRITE: i_Rst pulse -> Req/We drop same cycle, no R, MAR=MDR=0x0000, state IDLE.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and widths for the LC-3 memory access unit.
package lc3_mem_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mau_state_e;

endpackage : lc3_mem_pkg

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter: synchronous clear, count enable, terminal-count flag.
module mem_timeout_ctr
  import lc3_mem_pkg::*;
#(
  parameter int unsigned TERMINAL = 254
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c_o = (count_q == CNT_W'(TERMINAL));

endmodule : mem_timeout_ctr

// File: rtl/mem_access_unit.sv
// LC-3 MAR/MDR memory access unit: Moore FSM handshaking with memory,
// with a bounded wait that aborts to DONE and raises a sticky error.
module mem_access_unit
  import lc3_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [WORD_W-1:0] BUS_IN,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [WORD_W-1:0] i_Mem_Rdata,
  input  logic              i_Mem_Ready,
  output logic [WORD_W-1:0] o_Mem_Addr,
  output logic [WORD_W-1:0] o_Mem_Wdata,
  output logic              o_Mem_Req,
  output logic              o_Mem_We,
  output logic [WORD_W-1:0] MAR_OUT,
  output logic [WORD_W-1:0] MDR_OUT,
  output logic              R,
  output logic              o_Err
);

  localparam int unsigned TERMINAL = TIMEOUT_CYCLES - 1;

  mau_state_e        state_q, state_d;
  logic [WORD_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic              err_q, err_d;
  logic              busy;
  logic              tc;

  assign busy = (state_q == READ) || (state_q == WRITE);

  // Counter held at zero outside an access, so it starts from 0 on entry.
  mem_timeout_ctr #(
    .TERMINAL (TERMINAL)
  ) u_timeout_ctr (
    .clk_i  (i_Clk),
    .rst_i  (i_Rst),
    .clr_i  (!busy),
    .en_i   (busy),
    .tc_c_o (tc)
  );

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (LD_MAR) begin
          mar_d = BUS_IN;
        end
        if (LD_MDR && !MIO_EN) begin
          mdr_d = BUS_IN;
        end
        if (state_q == DONE) begin
          state_d = IDLE;
        end else if (MIO_EN) begin
          state_d = R_W ? WRITE : READ;
          err_d   = 1'b0;
        end
      end
      READ: begin
        // Ready wins over a coincident terminal count.
        if (i_Mem_Ready) begin
          mdr_d   = i_Mem_Rdata;
          state_d = DONE;
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (i_Mem_Ready) begin
          state_d = DONE;
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode the state register only.
  assign o_Mem_Req   = busy;
  assign o_Mem_We    = (state_q == WRITE);
  assign R           = (state_q == DONE);
  assign o_Err       = err_q;
  assign o_Mem_Addr  = mar_q;
  assign o_Mem_Wdata = mdr_q;
  assign MAR_OUT     = mar_q;
  assign MDR_OUT     = mdr_q;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions queued at
// request time and compared when R pulses.
module tb_mem_access_unit;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] rdata;
  logic        ready;
  logic [15:0] mem_addr, mem_wdata, mar_out, mdr_out;
  logic        mem_req, mem_we, r_o, err;

  typedef struct {
    logic [15:0] mdr;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] m_mar, m_mdr;
  logic        m_err;

  mem_access_unit #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .BUS_IN      (bus_in),
    .LD_MAR      (ld_mar),
    .LD_MDR      (ld_mdr),
    .MIO_EN      (mio_en),
    .R_W         (r_w),
    .i_Mem_Rdata (rdata),
    .i_Mem_Ready (ready),
    .o_Mem_Addr  (mem_addr),
    .o_Mem_Wdata (mem_wdata),
    .o_Mem_Req   (mem_req),
    .o_Mem_We    (mem_we),
    .MAR_OUT     (mar_out),
    .MDR_OUT     (mdr_out),
    .R           (r_o),
    .o_Err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // delay = busy cycle (1-based) in which Ready is shown; 0 means never.
  task automatic do_access(input logic rw, input logic [15:0] addr,
                           input logic [15:0] data, input int unsigned delay);
    exp_t        e;
    int unsigned edges;
    bit          got;
    bit          tmo;
    ld_mar = 1'b1; bus_in = addr; ready = 1'b1; rdata = ~data;
    step();
    ld_mar = 1'b0; ready = 1'b0; m_mar = addr;
    check_eq("idle_ready_ignored", 32'(mdr_out), 32'(m_mdr));
    check_eq("mar_load", 32'(mar_out), 32'(addr));
    if (rw) begin
      ld_mdr = 1'b1; bus_in = data;
      step();
      ld_mdr = 1'b0; m_mdr = data;
      check_eq("mdr_load", 32'(mdr_out), 32'(data));
    end
    check_eq("err_hold", 32'(err), 32'(m_err));
    tmo   = (delay == 0) || (delay > T);
    e.err = tmo;
    e.mdr = (rw || tmo) ? m_mdr : data;
    e.lat = tmo ? T + 1 : delay + 1;
    sb.push_back(e);

    mio_en = 1'b1; r_w = rw;
    step();
    mio_en = 1'b0; edges = 1; got = 1'b0;
    check_eq("err_clear_on_req", 32'(err), 32'd0);
    while (!got && edges <= T + 2) begin
      if (r_o) begin
        got = 1'b1;
        e = sb.pop_front();
        check_eq("latency", edges, e.lat);
        check_eq("done_mdr", 32'(mdr_out), 32'(e.mdr));
        check_eq("done_wdata", 32'(mem_wdata), 32'(e.mdr));
        check_eq("done_err", 32'(err), 32'(e.err));
        check_eq("done_mar", 32'(mar_out), 32'(addr));
        check_eq("done_req", 32'(mem_req), 32'd0);
        ld_mar = 1'b0; ld_mdr = 1'b0; ready = 1'b0;
        step();
        check_eq("r_one_cycle", 32'(r_o), 32'd0);
        check_eq("idle_req", 32'(mem_req), 32'd0);
        m_mdr = e.mdr; m_err = e.err;
      end else begin
        check_eq("busy_req", 32'(mem_req), 32'd1);
        check_eq("busy_we", 32'(mem_we), 32'(rw));
        check_eq("busy_addr", 32'(mem_addr), 32'(addr));
        check_eq("busy_mdr", 32'(mdr_out), 32'(m_mdr));
        ld_mar = 1'b1; ld_mdr = 1'b1; bus_in = 16'hFFFF;
        ready = (edges == delay);
        rdata = ready ? data : ~data;
        step();
        edges++;
      end
    end
    if (!got) begin
      check_eq("r_wait_expired", 32'(r_o), 32'd1);
      sb.delete();
      ld_mar = 1'b0; ld_mdr = 1'b0; ready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus_in = '0; ld_mar = 1'b0; ld_mdr = 1'b0;
    mio_en = 1'b0; r_w = 1'b0; rdata = '0; ready = 1'b0;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    #2;
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_r", 32'(r_o), 32'd0);
    check_eq("rst_mar", 32'(mar_out), 32'd0);
    check_eq("rst_mdr", 32'(mdr_out), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    do_access(1'b0, 16'h3000, 16'hBEEF, 1);   // basic read
    do_access(1'b1, 16'h4000, 16'h1234, 5);   // write, Ready after 5 cycles
    do_access(1'b0, 16'h5000, 16'hDEAD, 0);   // timeout
    do_access(1'b0, 16'h6000, 16'hA5A5, T);   // Ready on terminal edge
    do_access(1'b1, 16'h6100, 16'h0F0F, 0);   // write timeout
    for (int i = 0; i < 6; i++) begin
      do_access(1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom),
                $urandom_range(T + 1, 0));
    end

    // Reset in the middle of a write.
    ld_mar = 1'b1; bus_in = 16'h7000; step();
    ld_mar = 1'b0; ld_mdr = 1'b1; bus_in = 16'h5555; step();
    ld_mdr = 1'b0; mio_en = 1'b1; r_w = 1'b1; step();
    mio_en = 1'b0; step();
    check_eq("pre_rst_we", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_req", 32'(mem_req), 32'd0);
    check_eq("arst_we", 32'(mem_we), 32'd0);
    check_eq("arst_r", 32'(r_o), 32'd0);
    check_eq("arst_mar", 32'(mar_out), 32'd0);
    check_eq("arst_mdr", 32'(mdr_out), 32'd0);
    @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    step();
    check_eq("post_rst_r", 32'(r_o), 32'd0);
    check_eq("post_rst_req", 32'(mem_req), 32'd0);
    ready = 1'b0;
    step();
    check_eq("post_rst_r2", 32'(r_o), 32'd0);
    check_eq("post_rst_mdr", 32'(mdr_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_access_unit
